mem_port_arbiter: RTL and testbench

- Shares the single RAM port between the instruction-fetch requester and the load/store requester of the RISC-V core.
- Sequences one outstanding RAM transaction at a time and returns data to the owning requester.
- Drives mem_busy, which is the pipeline memory-wait condition feeding the hold/flush mode controller.
- Data side has priority over fetch; a streak limit prevents fetch starvation.

---
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between instruction fetch and load/store,
// one transaction in flight. Define MEM_ARB_TIMEOUT_EN to build the WAIT watchdog.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned MAX_DSTREAK    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_wstrb,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [3:0]        ram_wstrb,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack,
  output logic              mem_busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, IF_WAIT, D_WAIT} state_t;

  localparam int unsigned SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  state_t        state, state_nxt;
  logic [SW-1:0] streak;
  logic          if_elig, d_elig;
  logic          grant_d, grant_if;
  logic          done, abort;
  logic          timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A requester whose valid is pulsing is still holding its old request; mask it.
  always_comb begin
    if_elig   = if_req && !if_valid;
    d_elig    = d_req && !d_valid;
    grant_d   = 1'b0;
    grant_if  = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        grant_d  = d_elig && !(if_elig && streak == STREAK_MAX);
        grant_if = !grant_d && if_elig;
        if (grant_d)       state_nxt = D_WAIT;
        else if (grant_if) state_nxt = IF_WAIT;
      end
      IF_WAIT, D_WAIT: begin
        done  = ram_ack;
        abort = !ram_ack && timeout_hit;
        if (done || abort) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_wstrb <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
      streak    <= '0;
    end else begin
      ram_en   <= 1'b0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if (state == IDLE) begin
        if (grant_d && if_req) begin
          if (streak != STREAK_MAX) streak <= streak + 1'b1;
        end else if (grant_if || !if_req) begin
          streak <= '0;
        end
        if (grant_d) begin
          ram_en    <= 1'b1;
          ram_addr  <= d_addr;
          ram_we    <= d_we;
          ram_wstrb <= d_wstrb;
          ram_wdata <= d_wdata;
        end else if (grant_if) begin
          ram_en    <= 1'b1;
          ram_addr  <= if_addr;
          ram_we    <= 1'b0;
          ram_wstrb <= '0;
        end
      end
      if (done || abort) begin
        ram_we    <= 1'b0;
        ram_wstrb <= '0;
        if (state == IF_WAIT) begin
          if_rdata <= abort ? '0 : ram_rdata;
          if_valid <= 1'b1;
        end else begin
          // Stores keep the last load result; an aborted access returns zero.
          if (abort)        d_rdata <= '0;
          else if (!ram_we) d_rdata <= ram_rdata;
          d_valid <= 1'b1;
        end
      end
    end
  end

  assign mem_busy = (state != IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] wd;
  logic          err_q;

  assign timeout_hit = (wd == WW'(TIMEOUT_CYCLES - 1));
  assign err         = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd    <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE)  wd <= '0;
      else if (!ram_ack)  wd <= wd + 1'b1;
      if (abort) err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios, then randomized request/RAM traffic,
// all scored cycle by cycle against a behavioural reference of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXD = 3;
  localparam int TO   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, d_req, d_we, ram_ack;
  logic [AW-1:0] if_addr, d_addr, ram_addr;
  logic [DW-1:0] if_rdata, d_rdata, d_wdata, ram_wdata, ram_rdata;
  logic [3:0]    d_wstrb, ram_wstrb;
  logic          if_valid, d_valid, ram_en, ram_we, mem_busy, err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_DSTREAK(MAXD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_wstrb(ram_wstrb), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .mem_busy(mem_busy), .err(err)
  );

  typedef struct packed {
    logic        we;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;

  logic [31:0] fq[$];
  dreq_t       dq[$];
  logic [31:0] grant_log[$];
  logic [31:0] valid_log[$];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: owner 0=none 1=fetch 2=data; plus the expected port registers.
  int          owner = 0, wait_cnt = 0, dstreak = 0;
  logic        m_en = 0, m_we = 0, m_ifv = 0, m_dv = 0, m_err = 0;
  logic [3:0]  m_strb = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_ifr = 0, m_dr = 0;

  int          ack_wait = 0, lat = 1;
  logic        lat_rand = 0, idle_acks = 0, rand_traffic = 0, use_fix = 0;
  logic [31:0] fix_rdata = 0;
  int          n_en = 0, n_we = 0, n_st = 0, n_ifv = 0, n_dv = 0;

  function automatic dreq_t mk_d(input logic we, input logic [3:0] strb,
                                 input logic [31:0] addr, input logic [31:0] wdata);
    dreq_t r;
    r.we = we; r.strb = strb; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic f_ok, d_ok, timed_out;
    if (rst) begin
      owner = 0; dstreak = 0; wait_cnt = 0;
      m_en = 0; m_we = 0; m_strb = 0; m_addr = 0; m_wdata = 0;
      m_ifv = 0; m_dv = 0; m_ifr = 0; m_dr = 0; m_err = 0;
      return;
    end
    f_ok  = if_req && !m_ifv;
    d_ok  = d_req && !m_dv;
    m_ifv = 0; m_dv = 0; m_en = 0;
    if (owner == 0) begin
      if (d_ok && !(f_ok && dstreak >= MAXD)) begin
        dstreak = if_req ? ((dstreak < MAXD) ? dstreak + 1 : MAXD) : 0;
        owner = 2; m_addr = d_addr; m_we = d_we; m_strb = d_wstrb; m_wdata = d_wdata;
        m_en = 1; wait_cnt = 0;
      end else if (f_ok) begin
        dstreak = 0;
        owner = 1; m_addr = if_addr; m_we = 0; m_strb = 0;
        m_en = 1; wait_cnt = 0;
      end else if (!if_req) begin
        dstreak = 0;
      end
    end else begin
      timed_out = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      timed_out = !ram_ack && (wait_cnt + 1 == TO);
`endif
      if (ram_ack || timed_out) begin
        if (owner == 1) begin
          m_ifr = timed_out ? 32'h0 : ram_rdata;
          m_ifv = 1;
        end else begin
          if (timed_out)  m_dr = 32'h0;
          else if (!m_we) m_dr = ram_rdata;
          m_dv = 1;
        end
        if (timed_out) m_err = 1;
        m_we = 0; m_strb = 0; owner = 0;
      end else begin
        wait_cnt++;
      end
    end
  endtask

  task automatic check_all();
    chk("mem_busy",  32'(mem_busy),  32'(owner != 0));
    chk("ram_en",    32'(ram_en),    32'(m_en));
    chk("ram_we",    32'(ram_we),    32'(m_we));
    chk("ram_wstrb", 32'(ram_wstrb), 32'(m_strb));
    if (owner != 0) chk("ram_addr",  ram_addr,  m_addr);
    if (owner == 2) chk("ram_wdata", ram_wdata, m_wdata);
    chk("if_valid",  32'(if_valid),  32'(m_ifv));
    chk("d_valid",   32'(d_valid),   32'(m_dv));
    chk("if_rdata",  if_rdata,       m_ifr);
    chk("d_rdata",   d_rdata,        m_dr);
    chk("err",       32'(err),       32'(m_err));
    if (ram_en === 1'b1) begin n_en++; grant_log.push_back(ram_addr); end
    if (ram_we === 1'b1) n_we++;
    if (ram_we === 1'b1 && ram_wstrb === 4'b0011 && ram_wdata === 32'hDEADBEEF) n_st++;
    if (if_valid === 1'b1) begin n_ifv++; valid_log.push_back(32'd1); end
    if (d_valid === 1'b1)  begin n_dv++;  valid_log.push_back(32'd2); end
  endtask

  task automatic req_drive();
    if_req  = (fq.size() != 0);
    if_addr = if_req ? fq[0] : $urandom;
    d_req   = (dq.size() != 0);
    if (d_req) begin
      d_we = dq[0].we; d_wstrb = dq[0].strb; d_addr = dq[0].addr; d_wdata = dq[0].wdata;
    end else begin
      d_we = 1'($urandom); d_wstrb = 4'($urandom); d_addr = $urandom; d_wdata = $urandom;
    end
  endtask

  task automatic ram_drive();
    ram_rdata = use_fix ? fix_rdata : $urandom;
    if (owner != 0) begin
      if (m_en) ack_wait = lat_rand ? int'($urandom_range(4)) : lat;
      ram_ack = (ack_wait == 0);
      if (ack_wait > 0) ack_wait--;
    end else begin
      ram_ack = idle_acks && ($urandom_range(2) == 0);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (m_ifv && fq.size() != 0) void'(fq.pop_front());
    if (m_dv && dq.size() != 0)  void'(dq.pop_front());
    if (rand_traffic) begin
      if (fq.size() == 0 && $urandom_range(2) == 0) fq.push_back($urandom & 32'hFFFF_FFFC);
      if (dq.size() == 0 && $urandom_range(2) == 0)
        dq.push_back(mk_d(1'($urandom), 4'($urandom), $urandom, $urandom));
    end
    req_drive();
    ram_drive();
  endtask

  task automatic clear_logs();
    grant_log.delete(); valid_log.delete();
    n_en = 0; n_we = 0; n_st = 0; n_ifv = 0; n_dv = 0;
  endtask

  initial begin
    logic [31:0] saved_dr;
    bit          seen;
    int          k;

    rst = 1'b1; ram_ack = 1'b0; ram_rdata = '0;
    req_drive();
    repeat (2) cyc();
    chk("rst_ram_addr",  ram_addr,  32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk("rst_ram_en",    32'(ram_en), 32'd0);
    chk("rst_if_rdata",  if_rdata,  32'h0);
    rst = 1'b0;

    // fetch against a zero-wait RAM
    lat = 0; use_fix = 1; fix_rdata = 32'h0000_0013;
    fq.push_back(32'h100); req_drive();
    cyc();
    chk("f0_ram_en",  32'(ram_en),   32'd1);
    chk("f0_ram_addr", ram_addr,     32'h100);
    chk("f0_busy_c1", 32'(mem_busy), 32'd1);
    cyc();
    chk("f0_if_valid", 32'(if_valid), 32'd1);
    chk("f0_if_rdata", if_rdata,      32'h13);
    chk("f0_busy_c2",  32'(mem_busy), 32'd0);
    cyc();
    chk("f0_no_dup", 32'(ram_en), 32'd0);
    use_fix = 0;
    repeat (2) cyc();

    // simultaneous requests: data first
    lat = 1; clear_logs();
    fq.push_back(32'h100);
    dq.push_back(mk_d(1'b0, 4'hF, 32'h2000, 32'h0));
    req_drive();
    repeat (10) cyc();
    chk("sim_n_grants", grant_log.size(), 32'd2);
    chk("sim_grant0",   qget(grant_log, 0), 32'h2000);
    chk("sim_grant1",   qget(grant_log, 1), 32'h100);
    chk("sim_valid0",   qget(valid_log, 0), 32'd2);
    chk("sim_valid1",   qget(valid_log, 1), 32'd1);

    // back-to-back data against a held fetch stream
    clear_logs();
    fq.push_back(32'h100); fq.push_back(32'h104);
    for (int i = 0; i < 4; i++) dq.push_back(mk_d(1'b0, 4'hF, 32'h2000 + 32'(4 * i), 32'h0));
    req_drive();
    repeat (25) cyc();
    chk("stv_n_grants", grant_log.size(), 32'd6);
    chk("stv_g0", qget(grant_log, 0), 32'h2000);
    chk("stv_g1", qget(grant_log, 1), 32'h100);
    chk("stv_g2", qget(grant_log, 2), 32'h2004);
    chk("stv_g3", qget(grant_log, 3), 32'h104);
    chk("stv_g4", qget(grant_log, 4), 32'h2008);
    chk("stv_g5", qget(grant_log, 5), 32'h200C);

    // store with three wait cycles
    lat = 3; clear_logs(); saved_dr = m_dr;
    dq.push_back(mk_d(1'b1, 4'b0011, 32'h40, 32'hDEADBEEF)); req_drive();
    repeat (8) cyc();
    chk("st_en_cycles",   n_en,  32'd1);
    chk("st_we_cycles",   n_we,  32'd4);
    chk("st_held_cycles", n_st,  32'd4);
    chk("st_d_valids",    n_dv,  32'd1);
    chk("st_d_rdata",     d_rdata, saved_dr);

    // reset in the second D_WAIT cycle, stray ack afterwards
    lat = 10;
    dq.push_back(mk_d(1'b0, 4'hF, 32'h80, 32'h0)); req_drive();
    cyc(); cyc();
    clear_logs();
    rst = 1'b1; dq.delete(); req_drive();
    cyc();
    rst = 1'b0;
    chk("rm_busy_rst", 32'(mem_busy), 32'd0);
    cyc();
    ram_ack = 1'b1;
    repeat (4) cyc();
    chk("rm_d_valids", n_dv, 32'd0);
    chk("rm_grants",   n_en, 32'd0);
    chk("rm_busy",     32'(mem_busy), 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
    // watchdog abort on a RAM that never answers
    lat = 1000; seen = 0; k = 0;
    fq.push_back(32'h300); req_drive();
    for (int i = 1; i <= 20; i++) begin
      if (!seen) begin
        cyc();
        if (if_valid === 1'b1) begin seen = 1; k = i; end
      end
    end
    chk("to_cycles",   k,            32'd9);
    chk("to_if_rdata", if_rdata,     32'h0);
    chk("to_err",      32'(err),     32'd1);
    lat = 1;
    repeat (4) cyc();
    chk("to_err_sticky", 32'(err), 32'd1);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("to_err_cleared", 32'(err), 32'd0);
`else
    seen = 0; k = 0;
`endif

    // randomized traffic, stray idle acks, one reset mid-run
    lat_rand = 1; idle_acks = 1; rand_traffic = 1;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        rst = 1'b1; fq.delete(); dq.delete(); req_drive();
        cyc();
        rst = 1'b0;
      end else begin
        cyc();
      end
    end
    rand_traffic = 0;
    repeat (20) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
